// File: rtl/ads5296_tx_serializer.sv
// ADS5296-style transmit serializer: one 10-bit word per lane per 10-cycle frame, MSB first,
// with frame clock high for the first half. Ramp test source compiled in with ADS5296_TX_RAMP_EN.
module ads5296_tx_serializer #(
    parameter int          G_NUM_CHANS = 4,
    parameter logic [9:0]  G_IDLE_WORD = 10'h155
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      sync,
    input  logic [10*G_NUM_CHANS-1:0] din,
    input  logic                      din_valid,
    output logic                      din_ready,
    input  logic                      test_mode,
    output logic [G_NUM_CHANS-1:0]    dout,
    output logic                      fclk,
    output logic                      sync_out,
    output logic [15:0]               underflow_cnt
);

    localparam logic [3:0] LAST_BIT = 4'd9;

    logic [3:0] bit_cnt;
    logic       run;
    logic       sync_pending;
    logic [9:0] shreg     [G_NUM_CHANS];
    logic [9:0] load_word [G_NUM_CHANS];
    logic       test_mode_active;
    logic       load;
    logic       idle_load;

`ifdef ADS5296_TX_RAMP_EN
    logic [9:0] ramp;

    assign test_mode_active = test_mode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ramp <= '0;
        end else if (load && test_mode_active) begin
            ramp <= ramp + 10'd1;
        end
    end
`else
    logic unused_test_mode;

    assign test_mode_active = 1'b0;
    assign unused_test_mode = test_mode;
`endif

    // sync wins over a load in the same cycle, so a handshaked word is simply dropped
    assign din_ready = run && (bit_cnt == LAST_BIT) && !test_mode_active;
    assign load      = run && (bit_cnt == LAST_BIT) && !sync;
    assign idle_load = load && !test_mode_active && !din_valid;

    // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
    always_comb begin
        for (int c = 0; c < G_NUM_CHANS; c++) begin
            load_word[c] = G_IDLE_WORD;
            if (din_valid) begin
                load_word[c] = din[10*c +: 10];
            end
`ifdef ADS5296_TX_RAMP_EN
            if (test_mode_active) begin
                load_word[c] = ramp + 10'(c);
            end
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt      <= LAST_BIT;
            run          <= 1'b0;
            sync_pending <= 1'b0;
            dout         <= '0;
            fclk         <= 1'b0;
            sync_out     <= 1'b0;
            // NOTE: the shift registers are reset too, so a mid-frame reset leaves no stale bits.
            for (int c = 0; c < G_NUM_CHANS; c++) begin
                shreg[c] <= '0;
            end
        end else begin
            run      <= 1'b1;
            sync_out <= 1'b0;
            if (sync) begin
                bit_cnt      <= LAST_BIT;
                dout         <= '0;
                fclk         <= 1'b0;
                sync_pending <= 1'b1;
            end else if (load) begin
                bit_cnt      <= '0;
                fclk         <= 1'b1;
                sync_out     <= sync_pending;
                sync_pending <= 1'b0;
                for (int c = 0; c < G_NUM_CHANS; c++) begin
                    dout[c]  <= load_word[c][9];
                    shreg[c] <= {load_word[c][8:0], 1'b0};
                end
            end else if (run) begin
                // bit_cnt < 9 here: the 9 -> 0 wrap always goes through the load branch
                bit_cnt <= bit_cnt + 4'd1;
                fclk    <= (bit_cnt < 4'd4);
                for (int c = 0; c < G_NUM_CHANS; c++) begin
                    dout[c]  <= shreg[c][9];
                    shreg[c] <= {shreg[c][8:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underflow_cnt <= '0;
        end else if (idle_load && (underflow_cnt != 16'hFFFF)) begin
            underflow_cnt <= underflow_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_ads5296_tx_serializer.sv
// Scoreboard bench for ads5296_tx_serializer: stimulus queues expected frames, a monitor
// reassembles serial frames from dout/fclk/sync_out and compares. Ramp test needs ADS5296_TX_RAMP_EN.
module tb_ads5296_tx_serializer;

    localparam int NCH = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              sync = 1'b0;
    logic [10*NCH-1:0] din = '0;
    logic              din_valid = 1'b0;
    logic              din_ready;
    logic              test_mode = 1'b0;
    logic [NCH-1:0]    dout;
    logic              fclk;
    logic              sync_out;
    logic [15:0]       underflow_cnt;

    ads5296_tx_serializer #(.G_NUM_CHANS(NCH), .G_IDLE_WORD(10'h155)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sync          (sync),
        .din           (din),
        .din_valid     (din_valid),
        .din_ready     (din_ready),
        .test_mode     (test_mode),
        .dout          (dout),
        .fclk          (fclk),
        .sync_out      (sync_out),
        .underflow_cnt (underflow_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [10*NCH-1:0] words;
        int                len;
        logic [9:0]        fpat;
        logic              so;
    } frame_t;

    frame_t exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- monitor ----------------
    logic [9:0] got_w [NCH];
    logic [9:0] got_f, got_s;
    int         idx = 0;
    bit         collecting = 0;
    logic       prev_fclk = 1'b0;

    task automatic finalize_frame();
        frame_t            e;
        logic [10*NCH-1:0] gw;
        for (int c = 0; c < NCH; c++) gw[10*c +: 10] = got_w[c];
        check("frame_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("frame_len", 64'(idx), 64'(e.len));
            check("frame_words", 64'(gw), 64'(e.words));
            check("frame_fclk", 64'(got_f), 64'(e.fpat));
            check("frame_sync_out", 64'(got_s), 64'(10'(e.so) << (e.len - 1)));
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            collecting = 0;
            idx        = 0;
            prev_fclk  = 1'b0;
        end else begin
            if (fclk && !prev_fclk) begin
                if (collecting) finalize_frame();
                collecting = 1;
                idx        = 0;
                got_f      = '0;
                got_s      = '0;
                for (int c = 0; c < NCH; c++) got_w[c] = '0;
            end
            if (collecting) begin
                for (int c = 0; c < NCH; c++) got_w[c] = {got_w[c][8:0], dout[c]};
                got_f = {got_f[8:0], fclk};
                got_s = {got_s[8:0], sync_out};
                idx++;
                if (idx == 10) begin
                    finalize_frame();
                    collecting = 0;
                end
            end
            prev_fclk = fclk;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!din_ready && n < 30) begin
            tick();
            n++;
        end
        check("ready_timeout", 64'(din_ready), 64'd1);
    endtask

    // exp_val: per-lane bits the monitor should see (right-aligned when len < 10)
    task automatic send_frame(input bit valid, input logic [9:0] w, input int len,
                              input logic [9:0] exp_val, input logic so, input bit push);
        frame_t f;
        wait_ready();
        din_valid = valid;
        din       = {NCH{w}};
        if (push) begin
            f.words = {NCH{exp_val}};
            f.len   = len;
            f.fpat  = (len == 10) ? 10'b1111100000 : 10'b0000111110;
            f.so    = so;
            exp_q.push_back(f);
        end
        tick();
        din_valid = 1'b0;
    endtask

    // finishes the current frame and stops just before its trailing load edge
    task automatic drain();
        repeat (9) tick();
        @(negedge clk);
        #1;
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("ready_after_release", 64'(din_ready), 64'd0);
        tick();
        check("ready_cycle2", 64'(din_ready), 64'd1);
    endtask

    initial begin
        #200_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        #2 rst_n = 1'b0;
        #1;
        check("rst_dout", 64'(dout), 64'd0);
        check("rst_fclk", 64'(fclk), 64'd0);
        check("rst_sync_out", 64'(sync_out), 64'd0);
        check("rst_underflow", 64'(underflow_cnt), 64'd0);
        check("rst_ready", 64'(din_ready), 64'd0);
        release_reset();

        // 10'h2A5 -> 1010100101, then three idle frames -> 0101010101
        send_frame(1'b1, 10'h2A5, 10, 10'h2A5, 1'b0, 1'b1);
        check("underflow_after_data", 64'(underflow_cnt), 64'd0);
        send_frame(1'b1, 10'h2A5, 10, 10'h2A5, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) send_frame(1'b0, 10'h000, 10, 10'h155, 1'b0, 1'b1);
        check("underflow_3", 64'(underflow_cnt), 64'd3);

        // sync at bit_cnt 4: frame cut after bits 10101, then one zero cycle
        send_frame(1'b1, 10'h2A5, 6, 10'h02A, 1'b0, 1'b1);
        repeat (4) tick();
        sync = 1'b1;
        tick();
        sync = 1'b0;
        check("sync_dout", 64'(dout), 64'd0);
        check("sync_fclk", 64'(fclk), 64'd0);
        send_frame(1'b1, 10'h2A5, 10, 10'h2A5, 1'b1, 1'b1);
        check("underflow_sync", 64'(underflow_cnt), 64'd3);

        // sync held with valid data: ready stays high, words are dropped
        wait_ready();
        sync      = 1'b1;
        din_valid = 1'b1;
        din       = {NCH{10'h3FF}};
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ready_sync_held", 64'(din_ready), 64'd1);
        end
        sync      = 1'b0;
        din_valid = 1'b0;
        check("underflow_sync_held", 64'(underflow_cnt), 64'd3);
        send_frame(1'b0, 10'h000, 10, 10'h155, 1'b1, 1'b1);
        check("underflow_4", 64'(underflow_cnt), 64'd4);
        drain();

        // saturation: counter preset near the top instead of running 70000 frames
        rst_n = 1'b0;
        release_reset();
        force dut.underflow_cnt = 16'hFFFC;
        #1;
        release dut.underflow_cnt;
        send_frame(1'b0, 10'h000, 10, 10'h155, 1'b0, 1'b1);
        check("underflow_fffd", 64'(underflow_cnt), 64'hFFFD);
        send_frame(1'b0, 10'h000, 10, 10'h155, 1'b0, 1'b1);
        send_frame(1'b0, 10'h000, 10, 10'h155, 1'b0, 1'b1);
        check("underflow_ffff", 64'(underflow_cnt), 64'hFFFF);
        send_frame(1'b0, 10'h000, 10, 10'h155, 1'b0, 1'b1);
        check("underflow_no_wrap", 64'(underflow_cnt), 64'hFFFF);

        // asynchronous reset at bit_cnt 6 of an all-ones frame
        send_frame(1'b1, 10'h3FF, 10, 10'h3FF, 1'b0, 1'b0);
        repeat (6) tick();
        check("pre_reset_dout", 64'(dout), 64'hF);
        #1 rst_n = 1'b0;
        #1;
        check("async_dout", 64'(dout), 64'd0);
        check("async_fclk", 64'(fclk), 64'd0);
        check("async_underflow", 64'(underflow_cnt), 64'd0);
        check("async_ready", 64'(din_ready), 64'd0);
        release_reset();
        send_frame(1'b1, 10'h2A5, 10, 10'h2A5, 1'b0, 1'b1);
        check("underflow_resumed", 64'(underflow_cnt), 64'd0);
        drain();

`ifdef ADS5296_TX_RAMP_EN
        // ramp source: lane c carries (frame + c) mod 1024
        rst_n     = 1'b0;
        test_mode = 1'b1;
        for (int f = 0; f < 1025; f++) begin
            frame_t e;
            for (int c = 0; c < NCH; c++) e.words[10*c +: 10] = 10'((f + c) % 1024);
            e.len  = 10;
            e.fpat = 10'b1111100000;
            e.so   = 1'b0;
            exp_q.push_back(e);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        begin
            int n = 0;
            do begin
                @(negedge clk);
                #1;
                n++;
                if (n % 10 == 5) check("ramp_ready_low", 64'(din_ready), 64'd0);
            end while (exp_q.size() > 0 && n < 12000);
            check("ramp_underflow_frozen", 64'(underflow_cnt), 64'd0);
        end
        rst_n     = 1'b0;
        test_mode = 1'b0;
`endif

        repeat (3) @(posedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
